// File: rtl/race_condition_pipe.sv
// Elastic multi-lane add/subtract pipeline with valid/ready on both sides.
// Define RACE_CONDITION_PIPE_CNT_EN to add the 16-bit consumed-result counter res_cnt.
module race_condition_pipe #(
    parameter int N      = 4,
    parameter int LANES  = 2,
    parameter int STAGES = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [LANES*N-1:0]       a,
    input  logic [LANES*N-1:0]       b,
    input  logic [LANES-1:0]         op,
    input  logic                     arg_vld,
    output logic                     arg_rdy,
    output logic [LANES*(N+1)-1:0]   res,
    output logic                     res_vld,
`ifdef RACE_CONDITION_PIPE_CNT_EN
    input  logic                     res_rdy,
    output logic [15:0]              res_cnt
`else
    input  logic                     res_rdy
`endif
);

    localparam int W = LANES * (N + 1);

    logic [STAGES-1:0] vld;
    logic [STAGES-1:0] adv;
    logic [W-1:0]      data [STAGES];
    logic [W-1:0]      s0_result;

    // A stage may advance unless it and every stage after it are full while
    // the consumer stalls; this is the unrolled form of the adv chain and
    // lets empty slots upstream of a stalled output keep filling.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        adv = '0;
        for (int k = 0; k < STAGES; k++) begin
            logic full_tail;
            full_tail = 1'b1;
            for (int j = k; j < STAGES; j++) begin
                full_tail = full_tail & vld[j];
            end
            adv[k] = ~full_tail | res_rdy;
        end
    end

    // Per-lane arithmetic: N+1 bit result, carry or borrow lands in bit N.
    always_comb begin
        s0_result = '0;
        for (int i = 0; i < LANES; i++) begin
            if (op[i]) begin
                s0_result[i*(N+1) +: N+1] = {1'b0, a[i*N +: N]} - {1'b0, b[i*N +: N]};
            end else begin
                s0_result[i*(N+1) +: N+1] = {1'b0, a[i*N +: N]} + {1'b0, b[i*N +: N]};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            // NOTE: non-blocking assignments keep every stage reading the pre-edge value of its neighbour.
            vld <= '0;
            // NOTE: data registers are cleared too because res must read 0 during and just after reset.
            for (int k = 0; k < STAGES; k++) begin
                data[k] <= '0;
            end
        end else begin
            if (adv[0]) begin
                vld[0] <= arg_vld;
                if (arg_vld) begin
                    data[0] <= s0_result;
                end
            end
            for (int k = 1; k < STAGES; k++) begin
                if (adv[k]) begin
                    vld[k] <= vld[k-1];
                    if (vld[k-1]) begin
                        data[k] <= data[k-1];
                    end
                end
            end
        end
    end

    assign arg_rdy = adv[0] & rst;
    assign res_vld = vld[STAGES-1];
    assign res     = data[STAGES-1];

`ifdef RACE_CONDITION_PIPE_CNT_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            res_cnt <= '0;
        end else if (res_vld && res_rdy) begin
            res_cnt <= res_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_race_condition_pipe.sv
// Directed and random scoreboard bench for race_condition_pipe.
// Inputs change 1 time unit after posedge; outputs are sampled on negedge.
module tb_race_condition_pipe;

    localparam int N      = 4;
    localparam int LANES  = 2;
    localparam int STAGES = 2;
    localparam int W      = LANES * (N + 1);

    typedef logic [LANES*N-1:0] opnd_t;
    typedef logic [LANES-1:0]   lane_t;
    typedef logic [W-1:0]       res_t;

    logic  clk = 1'b0;
    logic  rst;
    opnd_t a, b;
    lane_t op;
    logic  arg_vld, arg_rdy;
    res_t  res;
    logic  res_vld, res_rdy;
`ifdef RACE_CONDITION_PIPE_CNT_EN
    logic [15:0] res_cnt;
    logic [15:0] cnt_model = '0;
`endif

    int   n_pass   = 0;
    int   n_checks = 0;
    int   n_acc    = 0;
    int   n_con    = 0;
    res_t sb[$];

    always #5 clk = ~clk;

    race_condition_pipe #(.N(N), .LANES(LANES), .STAGES(STAGES)) dut (
        .clk     (clk),
        .rst     (rst),
        .a       (a),
        .b       (b),
        .op      (op),
        .arg_vld (arg_vld),
        .arg_rdy (arg_rdy),
        .res     (res),
        .res_vld (res_vld),
`ifdef RACE_CONDITION_PIPE_CNT_EN
        .res_rdy (res_rdy),
        .res_cnt (res_cnt)
`else
        .res_rdy (res_rdy)
`endif
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Reference arithmetic done in plain integers, then wrapped to N+1 bits.
    function automatic res_t model(input opnd_t av, input opnd_t bv, input lane_t ov);
        res_t r;
        int   x, y, z;
        r = '0;
        for (int i = 0; i < LANES; i++) begin
            x = int'(av[i*N +: N]);
            y = int'(bv[i*N +: N]);
            z = ov[i] ? x - y : x + y;
            r[i*(N+1) +: N+1] = z[N:0];
        end
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: transfers seen here complete on the following posedge.
    always @(negedge clk) begin
        if (rst === 1'b1) begin
`ifdef RACE_CONDITION_PIPE_CNT_EN
            check("res_cnt", res_cnt, cnt_model);
            if (res_vld && res_rdy) cnt_model = cnt_model + 16'd1;
`endif
            if (res_vld && res_rdy) begin
                if (sb.size() == 0) begin
                    check("unexpected_result", res_vld, 1'b0);
                end else begin
                    check("result", res, sb.pop_front());
                end
                n_con++;
            end
            if (arg_vld && arg_rdy) begin
                sb.push_back(model(a, b, op));
                n_acc++;
            end
        end else begin
`ifdef RACE_CONDITION_PIPE_CNT_EN
            cnt_model = '0;
`endif
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        opnd_t ta[4];
        opnd_t tb_[4];
        lane_t to[4];
        int    idx, accepts, cyc, start;

        // Reset held with valid operands offered.
        rst = 1'b0; arg_vld = 1'b1; a = 8'h5A; b = 8'h33; op = 2'b01; res_rdy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_res_vld", res_vld, 1'b0);
            check("rst_res", res, '0);
            check("rst_arg_rdy", arg_rdy, 1'b0);
        end
        step();
        arg_vld = 1'b0; rst = 1'b1;
        @(negedge clk);
        check("post_rst_arg_rdy", arg_rdy, 1'b1);
        check("post_rst_res_vld", res_vld, 1'b0);
        check("post_rst_res", res, '0);
        for (int i = 0; i < 3; i++) begin
            step();
            @(negedge clk);
            check("post_rst_quiet", res_vld, 1'b0);
        end

        // Add with carry out of both lanes.
        step();
        a = {4'd7, 4'd15}; b = {4'd8, 4'd1}; op = 2'b00; arg_vld = 1'b1;
        @(negedge clk);
        check("add_arg_rdy", arg_rdy, 1'b1);
        step();
        arg_vld = 1'b0;
        @(negedge clk);
        check("add_lat1_vld", res_vld, 1'b0);
        step();
        @(negedge clk);
        check("add_lat2_vld", res_vld, 1'b1);
        check("add_res", res, {5'h0F, 5'h10});
        step();
        @(negedge clk);
        check("add_single_pulse", res_vld, 1'b0);

        // Subtract with and without borrow.
        a = {4'd9, 4'd3}; b = {4'd2, 4'd5}; op = 2'b11; arg_vld = 1'b1;
        step();
        arg_vld = 1'b0;
        step();
        @(negedge clk);
        check("sub_vld", res_vld, 1'b1);
        check("sub_res", res, {5'h07, 5'h1E});

        // Backpressure: only STAGES transactions fit.
        ta[0] = 8'h12; tb_[0] = 8'h34; to[0] = 2'b00;
        ta[1] = 8'hF0; tb_[1] = 8'h0F; to[1] = 2'b10;
        ta[2] = 8'hAB; tb_[2] = 8'hCD; to[2] = 2'b01;
        ta[3] = 8'h77; tb_[3] = 8'h88; to[3] = 2'b11;
        step();
        res_rdy = 1'b0; idx = 0; accepts = 0;
        for (int c = 0; c < 6; c++) begin
            arg_vld = 1'b1; a = ta[idx]; b = tb_[idx]; op = to[idx];
            @(negedge clk);
            if (arg_rdy && idx < 3) begin
                accepts++;
                idx++;
            end
            step();
        end
        arg_vld = 1'b1;
        @(negedge clk);
        check("bp_accepts", accepts, 2);
        check("bp_arg_rdy_low", arg_rdy, 1'b0);
        check("bp_res_vld", res_vld, 1'b1);
        check("bp_held_res", res, model(ta[0], tb_[0], to[0]));
        step();
        arg_vld = 1'b0; res_rdy = 1'b1;
        @(negedge clk);
        check("bp_arg_rdy_release", arg_rdy, 1'b1);
        check("bp_first", res, model(ta[0], tb_[0], to[0]));
        step();
        @(negedge clk);
        check("bp_second_vld", res_vld, 1'b1);
        check("bp_second", res, model(ta[1], tb_[1], to[1]));
        step();
        @(negedge clk);
        check("bp_drained", res_vld, 1'b0);

        // Random streaming against the scoreboard.
        start = n_acc; cyc = 0;
        while ((n_acc - start) < 1000 && cyc < 20000) begin
            arg_vld = ($urandom_range(0, 3) != 0);
            res_rdy = ($urandom_range(0, 2) != 0);
            a = opnd_t'($urandom); b = opnd_t'($urandom); op = lane_t'($urandom);
            step();
            cyc++;
        end
        arg_vld = 1'b0; res_rdy = 1'b1; cyc = 0;
        while (sb.size() > 0 && cyc < 100) begin
            step();
            cyc++;
        end
        check("stream_count", n_acc - start, 1000);
        check("stream_drained", sb.size(), 0);
        check("stream_balance", n_con, n_acc);

`ifdef RACE_CONDITION_PIPE_CNT_EN
        // Counter wrap: 70000 consumes from a fresh reset.
        rst = 1'b0; sb.delete();
        step();
        step();
        rst = 1'b1; arg_vld = 1'b1; res_rdy = 1'b1;
        start = n_con; cyc = 0;
        while ((n_con - start) < 70000 && cyc < 75000) begin
            a = opnd_t'($urandom); b = opnd_t'($urandom); op = lane_t'($urandom);
            step();
            cyc++;
        end
        arg_vld = 1'b0; res_rdy = 1'b0;
        @(negedge clk);
        check("res_cnt_wrap", res_cnt, 16'd4464);
        step();
`endif

        // Reset in the middle of a stream discards everything in flight.
        arg_vld = 1'b1; res_rdy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            a = opnd_t'($urandom); b = opnd_t'($urandom); op = lane_t'($urandom);
            step();
        end
        res_rdy = 1'b0;
        step();
        rst = 1'b0; sb.delete();
        step();
        @(negedge clk);
        check("mid_rst_res_vld", res_vld, 1'b0);
        check("mid_rst_arg_rdy", arg_rdy, 1'b0);
`ifdef RACE_CONDITION_PIPE_CNT_EN
        check("mid_rst_res_cnt", res_cnt, 16'd0);
`endif
        step();
        arg_vld = 1'b0; rst = 1'b1; res_rdy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("mid_rst_no_output", res_vld, 1'b0);
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/race_condition_pipe.md
Name: race_condition_pipe

Overview:
- Parametrised successor to the single-lane registered adder.
- Adds/subtracts LANES independent N-bit operand pairs through a STAGES-deep elastic pipeline.
- Uses a full valid/ready handshake on both sides, so throughput is one transaction per cycle and the pipeline absorbs backpressure without dropping data.
- Sits between an operand producer and a result consumer in the datapath test harness. Bound through an interface like its predecessor.

Parameters:
- N, 4, operand width per lane (>=1).
- LANES, 2, independent lanes per transaction (>=1).
- STAGES, 2, pipeline register stages, which is also the unstalled latency (>=1).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-low reset.
- a  input  LANES*N  operand A; lane i occupies bits [i*N +: N].
- b  input  LANES*N  operand B; same lane packing as a.
- op  input  LANES  per-lane operation: 0 = a+b, 1 = a-b.
- arg_vld  input  1  operands valid.
- arg_rdy  output  1  block can accept operands this cycle.
- res  output  LANES*(N+1)  results; lane i occupies bits [i*(N+1) +: N+1].
- res_vld  output  1  result valid.
- res_rdy  input  1  consumer accepts the result.

Behaviour:
- Reset is synchronous: sampled only on the clk rising edge when rst=0. Active-low, fixed.
- Values while in reset and on the first cycle after:
  - all stage valid bits = 0
  - res_vld = 0
  - res = 0
  - arg_rdy = 0 while rst=0; arg_rdy = 1 on the first cycle after rst=1.
- Arithmetic, per lane, computed in stage 0:
  - op=0: res = zero-extended {1'b0,a} + {1'b0,b}. Unsigned, so the carry out lands in bit N.
  - op=1: res = {1'b0,a} - {1'b0,b}, truncated to N+1 bits, i.e. two's complement.
  - Bit N is 1 iff a<b; no borrow is lost.
- Lanes never interact. A transaction's op and operands travel together.
- Pipeline:
  - Stages s0..s(STAGES-1), each holding a vld bit plus LANES*(N+1) data bits.
  - Output = last stage: res_vld = vld[STAGES-1], res = data[STAGES-1].
- Advance rule:
  - adv[STAGES-1] = ~vld[STAGES-1] | res_rdy.
  - adv[k] = ~vld[k] | adv[k+1].
  - Stage k loads from stage k-1 (or the input for k=0) when adv[k]. Otherwise it holds.
  - arg_rdy = adv[0] & rst.
- Bubbles collapse: a stalled output does not block upstream stages that still hold empty slots.
- Transfers:
  - Input accepted iff arg_vld & arg_rdy.
  - Output consumed iff res_vld & res_rdy.
  - A stage loaded with no incoming valid gets vld=0; its data may hold.
- Latency: exactly STAGES cycles from acceptance to res_vld when res_rdy is held high.
- Throughput: 1 transaction/cycle at steady state.
- Ordering: results are strictly in acceptance order; no transaction is dropped or duplicated.
- Capacity: with res_rdy=0, exactly STAGES transactions are accepted, then arg_rdy=0.
- Held output: while res_vld=1 and res_rdy=0, res stays stable. Held input: arg_vld/a/b/op may change freely when arg_rdy=0 (not sampled).
- Simultaneous accept and consume while full: allowed. The pipeline shifts and occupancy is unchanged.
- Reset mid-operation: all in-flight transactions are discarded. No res_vld pulse occurs after rst is asserted.

Optional Feature:
- Macro: RACE_CONDITION_PIPE_CNT_EN.
- Defined:
  - Adds output port res_cnt, 16 bits.
  - Counts consumed results (res_vld & res_rdy); wraps 16'hFFFF -> 0.
  - Reset to 0 by rst.
  - Reflects a consume on the clock edge after it occurs.
- Undefined: the port and counter are absent. All other behaviour is identical.

Test Plan:
- Reset: hold rst=0 for 3 cycles with arg_vld=1 -> res_vld=0, res=0, arg_rdy=0; no transaction appears after release.
- Add with carry, N=4, LANES=2, STAGES=2, res_rdy=1. Send lane0 a=15,b=1,op=0 and lane1 a=7,b=8,op=0 -> 2 cycles later res lane0=5'h10, lane1=5'h0F, res_vld high for 1 cycle.
- Subtract: lane0 a=3,b=5,op=1; lane1 a=9,b=2,op=1 -> lane0=5'h1E, lane1=5'h07.
- Backpressure: res_rdy=0, stream 4 distinct transactions -> only 2 accepted, arg_rdy=0 afterwards. Set res_rdy=1 -> results emerge in order, one per cycle, values intact, then arg_rdy=1.
- Streaming with random res_rdy/arg_vld, 1000 transactions, checked against a scoreboard -> zero mismatches and zero drops.
- With RACE_CONDITION_PIPE_CNT_EN: consume 70000 results -> res_cnt = 70000 mod 65536 = 4464. Then assert rst mid-stream -> res_cnt=0 and no further res_vld.
